// File: rtl/wb_regfile.sv
// Writeback stage end: load formatting, writeback source select, 32x32 integer
// register file with write-first bypass on both read ports, and the retire counter.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [1:0]      wb_sel,
    input  logic            regWEn,
    input  logic [4:0]      wb_rd,
    input  logic [2:0]      wb_funct3,
    input  logic [1:0]      wb_addr_lo,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_we,
    output logic [63:0]     instret
);

    logic [XLEN-1:0] regs [NREGS];
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_data;

    always_comb begin
        case (wb_addr_lo)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        // Halfword select ignores addr bit 0; misaligned halves are not split.
        ld_half = wb_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        case (wb_funct3)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        case (wb_sel)
            2'b00:   wb_data = load_data;
            2'b01:   wb_data = alu_result;
            2'b10:   wb_data = pc_plus4;
            default: wb_data = '0;
        endcase
    end

    assign wb_we = wb_valid & regWEn & (wb_sel != 2'b11) & (wb_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (wb_valid) begin
            instret <= instret + 64'd1;
        end
    end

    // x0 check comes first so a bypass can never leak a value onto x0.
    always_comb begin
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (wb_we && (rs1_addr == wb_rd)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs[rs1_addr];
        end
    end

    always_comb begin
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (wb_we && (rs2_addr == wb_rd)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs[rs2_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based
// reference model of the register file and retire counter.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [1:0]  wb_sel;
    logic        regWEn;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_funct3;
    logic [1:0]  wb_addr_lo;
    logic [31:0] mem_rdata;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [63:0] m_instret;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_sel     (wb_sel),
        .regWEn     (regWEn),
        .wb_rd      (wb_rd),
        .wb_funct3  (wb_funct3),
        .wb_addr_lo (wb_addr_lo),
        .mem_rdata  (mem_rdata),
        .alu_result (alu_result),
        .pc_plus4   (pc_plus4),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_data    (wb_data),
        .wb_we      (wb_we),
        .instret    (instret)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] raw,
                                             input logic [1:0] lo);
        logic [31:0] b;
        logic [31:0] h;
        b = (raw >> (8 * lo)) & 32'hFF;
        h = (raw >> (16 * lo[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b > 32'h7F)   ? (b | 32'hFFFFFF00) : b;
            3'b001:  return (h > 32'h7FFF) ? (h | 32'hFFFF0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return raw;
        endcase
    endfunction

    function automatic logic [31:0] ref_wb();
        case (wb_sel)
            2'd0:    return ref_load(wb_funct3, mem_rdata, wb_addr_lo);
            2'd1:    return alu_result;
            2'd2:    return pc_plus4;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_we();
        return wb_valid && regWEn && (wb_sel != 2'd3) && (wb_rd != 5'd0);
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (ref_we() && a == wb_rd) return ref_wb();
        return m_regs[a];
    endfunction

    // Call at the negative edge: compares all outputs with the model.
    task automatic check_model();
        chk("wb_data", wb_data, ref_wb());
        chk("wb_we", wb_we, ref_we());
        chk("rs1_data", rs1_data, ref_read(rs1_addr));
        chk("rs2_data", rs2_data, ref_read(rs2_addr));
        chk("instret", instret, m_instret);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_instret = 64'h0;
        end else begin
            if (ref_we()) m_regs[wb_rd] = ref_wb();
            if (wb_valid) m_instret = m_instret + 64'd1;
        end
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        advance();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; wb_valid = 1'b0; wb_sel = 2'd1; regWEn = 1'b0; wb_rd = 5'd0;
        wb_funct3 = 3'd2; wb_addr_lo = 2'd0; mem_rdata = 32'h0; alu_result = 32'h0;
        pc_plus4 = 32'h0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    task automatic set_write(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val);
        wb_valid = 1'b1; regWEn = 1'b1; wb_sel = sel; wb_rd = rd;
        alu_result = val; pc_plus4 = val;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                             input logic [31:0] exp);
        idle_inputs();
        wb_sel = 2'd0; wb_funct3 = f3; wb_addr_lo = lo; mem_rdata = 32'h80FF7F01;
        @(negedge clk);
        chk(tag, wb_data, exp);
        check_model();
        advance();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        m_instret = 64'h0;
        rst = 1'b0;

        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            cycle();
        end

        // Same-cycle bypass, then read back from the array under a bubble.
        idle_inputs();
        set_write(2'd1, 5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5;
        @(negedge clk);
        chk("bypass_rs1", rs1_data, 32'hDEADBEEF);
        check_model();
        advance();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("array_rs1", rs1_data, 32'hDEADBEEF);
        check_model();
        advance();

        load_case("lb3",  3'b000, 2'd3, 32'hFFFFFF80);
        load_case("lbu3", 3'b100, 2'd3, 32'h00000080);
        load_case("lh2",  3'b001, 2'd2, 32'hFFFF80FF);
        load_case("lhu0", 3'b101, 2'd0, 32'h00007F01);
        load_case("lw",   3'b010, 2'd0, 32'h80FF7F01);

        // Suppression: rd=0, reserved select, bubble.
        idle_inputs();
        set_write(2'd1, 5'd0, 32'h12345678);
        @(negedge clk);
        chk("x0_we", wb_we, 1'b0);
        check_model();
        advance();
        set_write(2'd3, 5'd9, 32'h11111111);
        cycle();
        set_write(2'd1, 5'd10, 32'h22222222);
        wb_valid = 1'b0;
        cycle();
        idle_inputs();
        rs1_addr = 5'd9; rs2_addr = 5'd10;
        @(negedge clk);
        chk("sel11_nowrite", rs1_data, 32'h0);
        chk("bubble_nowrite", rs2_data, 32'h0);
        check_model();
        advance();

        // Clean count from reset, JAL link write, then ten retirements.
        rst = 1'b1;
        cycle();
        idle_inputs();
        set_write(2'd2, 5'd1, 32'h00000104);
        cycle();
        for (int i = 0; i < 10; i++) begin
            set_write(2'd1, 5'($urandom_range(31, 2)), $urandom);
            regWEn = 1'($urandom);
            rs1_addr = 5'd1;
            cycle();
        end
        idle_inputs();
        rs1_addr = 5'd1;
        @(negedge clk);
        chk("x1_link", rs1_data, 32'h104);
        chk("instret_11", instret, 64'd11);
        check_model();
        advance();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_instret", instret, 64'd0);
        chk("rst_x1", rs1_data, 32'h0);
        check_model();
        advance();

        // A write coinciding with reset is dropped.
        rst = 1'b1;
        set_write(2'd1, 5'd7, 32'hCAFEF00D);
        cycle();
        idle_inputs();
        rs2_addr = 5'd7;
        @(negedge clk);
        chk("rst_drops_x7", rs2_data, 32'h0);
        check_model();
        advance();

        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(63) == 0);
            wb_valid   = 1'($urandom);
            wb_sel     = 2'($urandom);
            regWEn     = ($urandom_range(3) != 0);
            wb_rd      = 5'($urandom);
            wb_funct3  = 3'($urandom);
            wb_addr_lo = 2'($urandom);
            mem_rdata  = $urandom;
            alu_result = $urandom;
            pc_plus4   = $urandom;
            rs1_addr   = ($urandom_range(3) == 0) ? wb_rd : 5'($urandom);
            rs2_addr   = ($urandom_range(3) == 0) ? wb_rd : 5'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side consumer of the `wb_sel`/`regWEn` control pair. It formats load data, selects the writeback source, and commits the result into the 32×32 integer register file. It serves the decode stage's two read ports with same-cycle write bypass and counts retired instructions. It sits at the end of the rv32 pipeline, fed by the writeback pipeline registers and the writeback control stage.

## Interface
Parameters:
- XLEN, 32, data width (only 32 supported)
- NREGS, 32, register count; x0 hardwired to zero

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback slot holds a real instruction (0 = bubble)
- wb_sel  in  2  source select: 00 load data, 01 ALU result, 10 PC+4, 11 reserved
- regWEn  in  1  register write enable from writeback control
- wb_rd  in  5  destination register (instruction[11:7])
- wb_funct3  in  3  load width/sign (instruction[14:12])
- wb_addr_lo  in  2  low bits of the load effective address
- mem_rdata  in  32  raw aligned word from data memory
- alu_result  in  32  ALU/LUI/AUIPC result
- pc_plus4  in  32  link value for JAL/JALR
- rs1_addr  in  5  read port 1 address
- rs2_addr  in  5  read port 2 address
- rs1_data  out  32  read port 1 data (bypassed)
- rs2_data  out  32  read port 2 data (bypassed)
- wb_data  out  32  selected writeback value (forwarding source)
- wb_we  out  1  qualified write enable this cycle (forwarding qualifier)
- instret  out  64  retired-instruction counter

## Operation
- Load formatting on `wb_funct3`:
  - 000 LB: byte `wb_addr_lo` of `mem_rdata`, sign-extended.
  - 001 LH: halfword `wb_addr_lo[1]`, sign-extended; `wb_addr_lo[0]` ignored.
  - 010 LW: full word.
  - 100 LBU and 101 LHU: as LB/LH, zero-extended.
  - 011, 110, 111: raw `mem_rdata`.
- `wb_data`: 00 → formatted load, 01 → `alu_result`, 10 → `pc_plus4`, 11 → 32'h0. Purely combinational.
- `wb_we` = `wb_valid & regWEn & (wb_sel != 2'b11) & (wb_rd != 0)`.
- Write: on a rising edge with `wb_we`=1 and `rst`=0, `regs[wb_rd]` ← `wb_data`. x0 is never written and always reads 0.
- Read ports are combinational. If `rsN_addr == wb_rd` and `wb_we`=1, `rsN_data` = `wb_data` (write-first bypass). If `rsN_addr == 0`, `rsN_data` = 0. Otherwise `rsN_data` = `regs[rsN_addr]`. Both ports are independent and may read the same register.
- `instret` increments by 1 on each rising edge with `wb_valid`=1, regardless of `regWEn`. Branches and stores retire. It wraps from 2^64−1 to 0.
- No state machine. State consists of 31 data registers and the 64-bit counter.

## Timing
- Reset, checked at the clock edge:
  - All 31 registers become 0 and `instret` becomes 0.
  - Outputs then read as `rs1_data`=`rs2_data`=0. `wb_data` and `wb_we` follow their inputs combinationally.
  - A write or count pending in the reset cycle is dropped; reset dominates.
- Write latency: the value lands in the array at the edge ending the write cycle. It is visible on the read ports in that same cycle through the bypass, and from the array afterwards.
- Back-to-back writes to the same rd: the later one wins. A read in the second cycle sees the second value via bypass.
- A bubble (`wb_valid`=0) suppresses both the write and the count, even with `regWEn`=1.
- No handshakes and no stall input. The upstream pipeline holds or bubbles `wb_valid`.

## Test plan
- Reset, then read all 32 addresses on both ports → all 0, `instret`=0.
- wb_sel=01, regWEn=1, rd=5, alu_result=32'hDEADBEEF; rs1_addr=5 in the same cycle → rs1_data=32'hDEADBEEF in that cycle. Next cycle with wb_valid=0 → still 32'hDEADBEEF from the array.
- Loads with mem_rdata=32'h80FF7F01:
  - LB, addr_lo=3 → 32'hFFFFFF80.
  - LBU, addr_lo=3 → 32'h00000080.
  - LH, addr_lo=2 → 32'hFFFF80FF.
  - LHU, addr_lo=0 → 32'h00007F01.
  - LW → 32'h80FF7F01.
- Write suppression:
  - rd=0 with regWEn=1 → x0 reads 0 and wb_we=0.
  - wb_sel=11 → no write.
  - wb_valid=0 → no write, instret unchanged.
- JAL-style write: wb_sel=10, pc_plus4=32'h00000104, rd=1 → x1=32'h104. Then 10 valid cycles (mixed regWEn) → instret=11. Assert rst for one cycle → instret=0 and x1=0.
- Write with rd=7 while rst=1 → x7 stays 0 after reset deasserts.
